// File: rtl/cmd_seq_sender.sv
// -----------------------------------------------------------------------------
// cmd_seq_sender
//
// Command sequencer for the Knight's Tour command path. Buffers up to DEPTH
// commands from a host and issues them to the UART command transmitter one at
// a time. Each command is presented on cmd, then strobed with a single-cycle
// send_cmd pulse. The block then waits for a rising edge on resp_rdy, which
// acknowledges the command and captures the response byte. A wait longer than
// TIMEOUT_CYC cycles is reported on timeout_err.
//
// Optional feature (compile-time macro CMD_SEQ_RETRY_EN):
//   defined   - a timed-out command is resent up to MAX_RETRY times before
//               timeout_err is raised.
//   undefined - the first timeout raises timeout_err; MAX_RETRY is unused.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   push         enqueue push_cmd this cycle
//   push_cmd     command to enqueue
//   flush        drop the queue and abort any in-flight command
//   full/empty   FIFO status
//   count        number of FIFO entries
//   overflow     sticky: a push was dropped because the FIFO was full
//   cmd          command to the transmitter, held until the next pop
//   send_cmd     one-cycle send strobe
//   resp_rdy     response ready from the receiver (rising edge = ack)
//   resp         response byte
//   busy         sequencer is not idle
//   done_vld     one-cycle: command acknowledged
//   done_resp    response byte captured on the ack edge
//   timeout_err  one-cycle: command finally timed out
// -----------------------------------------------------------------------------
module cmd_seq_sender #(
    parameter int CMD_W       = 16,
    parameter int RESP_W      = 8,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 20000000,
    parameter int MAX_RETRY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [CMD_W-1:0]         push_cmd,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CMD_W-1:0]         cmd,
    output logic                     send_cmd,
    input  logic                     resp_rdy,
    input  logic [RESP_W-1:0]        resp,
    output logic                     busy,
    output logic                     done_vld,
    output logic [RESP_W-1:0]        done_resp,
    output logic                     timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    // Circular pointers rely on natural wrap-around, so DEPTH must be 2^n.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_RETRY < 0) begin : g_bad_param
        $error("cmd_seq_sender: DEPTH must be a power of 2 >= 2 and MAX_RETRY >= 0");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t             state;
    logic [CMD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [TMR_W-1:0]   timer;
    logic               resp_rdy_q;
    logic               ack_edge;
    logic               pop;
    logic               push_ok;

`ifdef CMD_SEQ_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTY_W-1:0]   retry_cnt;
`endif

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign busy     = (state != IDLE);
    assign ack_edge = resp_rdy & ~resp_rdy_q;

    // The FSM only pops from IDLE; no bypass, so a fresh push is seen one
    // cycle after it lands. A pop in the same cycle frees a slot for a push.
    assign pop     = (state == IDLE) && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop);

    // NOTE: FIFO storage has no reset; only pointers and count define which
    // entries are valid, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd         <= '0;
            send_cmd    <= 1'b0;
            timer       <= '0;
            // Preset high so a resp_rdy already high out of reset is not an edge.
            resp_rdy_q  <= 1'b1;
            done_vld    <= 1'b0;
            done_resp   <= '0;
            timeout_err <= 1'b0;
`ifdef CMD_SEQ_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            resp_rdy_q  <= resp_rdy;
            done_vld    <= 1'b0;
            timeout_err <= 1'b0;
            if (flush) begin
                state    <= IDLE;
                send_cmd <= 1'b0;
                timer    <= '0;
`ifdef CMD_SEQ_RETRY_EN
                retry_cnt <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            cmd   <= mem[rd_ptr];
                            state <= SETUP;
`ifdef CMD_SEQ_RETRY_EN
                            retry_cnt <= '0;
`endif
                        end
                    end
                    SETUP: begin
                        send_cmd <= 1'b1;
                        state    <= PULSE;
                    end
                    PULSE: begin
                        send_cmd <= 1'b0;
                        timer    <= '0;
                        if (ack_edge) begin
                            done_vld  <= 1'b1;
                            done_resp <= resp;
                            state     <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        timer <= timer + 1'b1;
                        // Ack is checked first so it wins over a same-cycle timeout.
                        if (ack_edge) begin
                            done_vld  <= 1'b1;
                            done_resp <= resp;
                            state     <= IDLE;
                        end else if (timer == TMR_LAST) begin
`ifdef CMD_SEQ_RETRY_EN
                            if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= SETUP;
                            end else begin
                                timeout_err <= 1'b1;
                                state       <= IDLE;
                            end
`else
                            timeout_err <= 1'b1;
                            state       <= IDLE;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_seq_sender.sv
// -----------------------------------------------------------------------------
// tb_cmd_seq_sender
//
// Self-checking bench for cmd_seq_sender. A responder answers each send_cmd
// pulse according to a plan of delays; a transaction-level model derives, from
// push times and the plan, the cycle and value of every send, ack and timeout.
// Honours CMD_SEQ_RETRY_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmd_seq_sender;

    localparam int CMD_W     = 16;
    localparam int RESP_W    = 8;
    localparam int DEPTH     = 8;
    localparam int T         = 100;
    localparam int MAX_RETRY = 2;
`ifdef CMD_SEQ_RETRY_EN
    localparam int MAX_SENDS = MAX_RETRY + 1;
`else
    localparam int MAX_SENDS = 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    push;
    logic [CMD_W-1:0]        push_cmd;
    logic                    flush;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic [CMD_W-1:0]        cmd;
    logic                    send_cmd;
    logic                    resp_rdy;
    logic [RESP_W-1:0]       resp;
    logic                    busy;
    logic                    done_vld;
    logic [RESP_W-1:0]       done_resp;
    logic                    timeout_err;

    cmd_seq_sender #(
        .CMD_W(CMD_W), .RESP_W(RESP_W), .DEPTH(DEPTH),
        .TIMEOUT_CYC(T), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .flush(flush),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .cmd(cmd), .send_cmd(send_cmd), .resp_rdy(resp_rdy), .resp(resp),
        .busy(busy), .done_vld(done_vld), .done_resp(done_resp),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Responder plan: one entry per send_cmd pulse, consumed in order.
    // Delay d >= 0 raises resp_rdy d cycles after the pulse cycle; -1 = no answer.
    int                 plan_d[$];
    logic [RESP_W-1:0]  plan_r[$];
    int                 plan_used = 0;

    // Observed events (written only by the monitor).
    int                 act_send_cyc[$];
    logic [CMD_W-1:0]   act_send_cmd[$];
    logic [CMD_W-1:0]   act_send_prev[$];
    int                 act_done_cyc[$];
    logic [RESP_W-1:0]  act_done_resp[$];
    int                 act_to_cyc[$];

    logic [CMD_W-1:0]   scn_cmd[$];
    int                 scn_pc[$];

    initial begin : monitor
        logic [CMD_W-1:0] prev_cmd;
        prev_cmd = '0;
        forever begin
            @(negedge clk);
            if (send_cmd === 1'b1) begin
                act_send_cyc.push_back(cyc);
                act_send_cmd.push_back(cmd);
                act_send_prev.push_back(prev_cmd);
            end
            if (done_vld === 1'b1) begin
                act_done_cyc.push_back(cyc);
                act_done_resp.push_back(done_resp);
            end
            if (timeout_err === 1'b1) act_to_cyc.push_back(cyc);
            prev_cmd = cmd;
        end
    end

    initial begin : responder
        int ridx, d, pcnt;
        bit pend;
        logic [RESP_W-1:0] presp;
        ridx = 0; pend = 0; pcnt = 0; presp = '0;
        resp_rdy = 1'b0;
        resp = '0;
        forever begin
            @(negedge clk);
            resp_rdy = 1'b0;
            if (pend) begin
                if (pcnt == 0) begin
                    resp_rdy = 1'b1;
                    resp = presp;
                    pend = 0;
                end else begin
                    pcnt--;
                end
            end
            if (send_cmd === 1'b1) begin
                d = (ridx < plan_d.size()) ? plan_d[ridx] : -1;
                presp = (ridx < plan_r.size()) ? plan_r[ridx] : '0;
                ridx++;
                if (d == 0) begin
                    resp_rdy = 1'b1;
                    resp = presp;
                end else if (d > 0) begin
                    pend = 1;
                    pcnt = d - 1;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int pick_delay();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0:       return -1;
            1:       return T;
            2:       return T + 1;
            3:       return 0;
            default: return $urandom_range(1, 30);
        endcase
    endfunction

    task automatic add_plan(input int d);
        plan_d.push_back(d);
        plan_r.push_back(RESP_W'($urandom_range(1, 255)));
    endtask

    task automatic push_list();
        scn_pc.delete();
        foreach (scn_cmd[i]) begin
            @(negedge clk);
            push = 1'b1;
            push_cmd = scn_cmd[i];
            scn_pc.push_back(cyc);
        end
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Pushes scn_cmd back-to-back into an idle sequencer, predicts the event
    // schedule, waits for it to play out and compares.
    task automatic run_scenario(input string name, input int exp_cnt);
        int bs, bd, bt, p, e, s, d;
        int                exp_sc[$];
        logic [CMD_W-1:0]  exp_scmd[$];
        int                exp_dc[$];
        logic [RESP_W-1:0] exp_dr[$];
        int                exp_tc[$];
        bs = act_send_cyc.size();
        bd = act_done_cyc.size();
        bt = act_to_cyc.size();
        push_list();
        if (exp_cnt >= 0) check({name, " count_after_push"}, 64'(count), 64'(exp_cnt));

        // Push accepted at edge k -> send at k+2; a finished command (done or
        // final timeout at cycle e) frees the sequencer for a send at e+2.
        // An answer counts if it arrives within T cycles after the pulse.
        p = plan_used;
        e = -1000;
        foreach (scn_cmd[i]) begin
            s = (scn_pc[i] + 3 > e + 2) ? scn_pc[i] + 3 : e + 2;
            for (int a = 0; a < MAX_SENDS; a++) begin
                exp_sc.push_back(s);
                exp_scmd.push_back(scn_cmd[i]);
                d = plan_d[p];
                p++;
                if (d >= 0 && d <= T) begin
                    exp_dc.push_back(s + d + 1);
                    exp_dr.push_back(plan_r[p-1]);
                    e = s + d + 1;
                    break;
                end
                if (a == MAX_SENDS - 1) begin
                    exp_tc.push_back(s + T + 1);
                    e = s + T + 1;
                end else begin
                    s = s + T + 2;
                end
            end
        end
        plan_used = p;
        while (plan_d.size() > p) begin
            void'(plan_d.pop_back());
            void'(plan_r.pop_back());
        end

        wait_until(e + 6);

        check({name, " n_send"}, 64'(act_send_cyc.size() - bs), 64'(exp_sc.size()));
        for (int i = 0; i < exp_sc.size(); i++) begin
            if (bs + i < act_send_cyc.size()) begin
                check($sformatf("%s send%0d_cyc", name, i), 64'(act_send_cyc[bs+i]), 64'(exp_sc[i]));
                check($sformatf("%s send%0d_cmd", name, i), 64'(act_send_cmd[bs+i]), 64'(exp_scmd[i]));
                check($sformatf("%s send%0d_cmd_early", name, i), 64'(act_send_prev[bs+i]), 64'(exp_scmd[i]));
            end
        end
        check({name, " n_done"}, 64'(act_done_cyc.size() - bd), 64'(exp_dc.size()));
        for (int i = 0; i < exp_dc.size(); i++) begin
            if (bd + i < act_done_cyc.size()) begin
                check($sformatf("%s done%0d_cyc", name, i), 64'(act_done_cyc[bd+i]), 64'(exp_dc[i]));
                check($sformatf("%s done%0d_resp", name, i), 64'(act_done_resp[bd+i]), 64'(exp_dr[i]));
            end
        end
        check({name, " n_timeout"}, 64'(act_to_cyc.size() - bt), 64'(exp_tc.size()));
        for (int i = 0; i < exp_tc.size(); i++) begin
            if (bt + i < act_to_cyc.size())
                check($sformatf("%s to%0d_cyc", name, i), 64'(act_to_cyc[bt+i]), 64'(exp_tc[i]));
        end
        check({name, " end_count"}, 64'(count), 64'd0);
        check({name, " end_empty"}, 64'(empty), 64'd1);
        check({name, " end_busy"},  64'(busy),  64'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " full"},        64'(full),        64'd0);
        check({name, " empty"},       64'(empty),       64'd1);
        check({name, " count"},       64'(count),       64'd0);
        check({name, " overflow"},    64'(overflow),    64'd0);
        check({name, " cmd"},         64'(cmd),         64'd0);
        check({name, " send_cmd"},    64'(send_cmd),    64'd0);
        check({name, " busy"},        64'(busy),        64'd0);
        check({name, " done_vld"},    64'(done_vld),    64'd0);
        check({name, " done_resp"},   64'(done_resp),   64'd0);
        check({name, " timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    initial begin : stimulus
        int bs, bd, bt, c0, n;
        rst = 1'b1;
        push = 1'b0;
        push_cmd = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single command, ack 10 cycles after the pulse.
        scn_cmd = '{16'h0000};
        add_plan(10);
        run_scenario("single", 1);

        // Three back-to-back commands, each acked after 5 cycles.
        scn_cmd = '{16'h2111, 16'h4023, 16'h6001};
        repeat (3) add_plan(5);
        run_scenario("b2b", 2);

        // No answer to the first command, the queued second one follows.
        scn_cmd = '{16'h1234, 16'h5678};
        repeat (MAX_SENDS) add_plan(-1);
        add_plan(3);
        run_scenario("timeout", -1);

        // Ack on the last counted cycle wins; one cycle later is too late.
        scn_cmd = '{16'hA001, 16'hA002, 16'hA003};
        add_plan(T);
        repeat (MAX_SENDS) add_plan(T + 1);
        add_plan(0);
        run_scenario("ack_boundary", -1);

        // Randomised command streams.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 6);
            scn_cmd.delete();
            for (int i = 0; i < n; i++) scn_cmd.push_back(CMD_W'($urandom));
            repeat (n * MAX_SENDS) add_plan(pick_delay());
            run_scenario($sformatf("rand%0d", r), -1);
        end

        // Fill the FIFO while the sequencer sits in WAIT, then flush.
        bs = act_send_cyc.size();
        bd = act_done_cyc.size();
        bt = act_to_cyc.size();
        add_plan(-1);
        plan_used++;
        scn_cmd = '{16'hBEEF};
        push_list();
        repeat (4) @(negedge clk);
        scn_cmd.delete();
        for (int i = 0; i < DEPTH + 1; i++) scn_cmd.push_back(CMD_W'(16'hC000 + i));
        push_list();
        check("ovf full",     64'(full),     64'd1);
        check("ovf count",    64'(count),    64'(DEPTH));
        check("ovf overflow", 64'(overflow), 64'd1);
        check("ovf busy",     64'(busy),     64'd1);
        flush = 1'b1;
        push = 1'b1;
        push_cmd = 16'hDEAD;
        @(negedge clk);
        flush = 1'b0;
        push = 1'b0;
        check("flush empty",    64'(empty),    64'd1);
        check("flush count",    64'(count),    64'd0);
        check("flush busy",     64'(busy),     64'd0);
        check("flush send_cmd", 64'(send_cmd), 64'd0);
        check("flush overflow_sticky", 64'(overflow), 64'd1);
        repeat (T + 20) @(negedge clk);
        check("flush n_send",    64'(act_send_cyc.size() - bs), 64'd1);
        check("flush n_done",    64'(act_done_cyc.size() - bd), 64'd0);
        check("flush n_timeout", 64'(act_to_cyc.size() - bt),   64'd0);
        check("flush still_empty", 64'(empty), 64'd1);

        // Reset while the sequencer is in SETUP.
        bs = act_send_cyc.size();
        @(negedge clk);
        push = 1'b1;
        push_cmd = 16'h7E57;
        c0 = cyc;
        @(negedge clk);
        push = 1'b0;
        wait_until(c0 + 2);
        check("setup busy",     64'(busy),     64'd1);
        check("setup cmd",      64'(cmd),      64'h7E57);
        check("setup send_cmd", 64'(send_cmd), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("rst_mid_setup");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst n_send", 64'(act_send_cyc.size() - bs), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
